// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   NUM_CH_DEF, DIV_W_DEF, DEFAULT_DIV_DEF - default parameter values
//   div_t      - divisor/counter word at the default width
//   ch_state_t - per-channel register layout at the default width
//   sel_width  - channel-select width, never less than one bit
package clk_div_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int DIV_W_DEF       = 31;
  localparam int DEFAULT_DIV_DEF = 1;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Per-channel register set: up-counter, active divisor, waiting divisor
  // with its valid flag, square output and wrap strobe.
  typedef struct packed {
    div_t cnt;
    div_t div_q;
    div_t pend_q;
    logic pend_v;
    logic out;
    logic tick;
  } ch_state_t;

  // A single-channel build still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: half-period of div_q+1 cycles, square output plus wrap tick.
// Latency: outputs registered; first tick div_q+1 cycles after enable from idle.
// Backpressure: none; divisor writes are always accepted (deferred to the wrap when running).
//
// Ports:
//   clk_i       system clock, posedge
//   rst_i       synchronous active-high reset
//   en_i        run enable; low holds the channel idle with output low
//   sync_i      phase realign: behaves like a momentary disable
//   wr_i        divisor write strobe for this channel
//   wr_data_i   divisor value written
//   out_o       divided square output
//   tick_o      one-cycle strobe on each wrap
//   pend_o      a written divisor is waiting for the next wrap
module clock_divider_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_data_i,
  output logic             out_o,
  output logic             tick_o,
  output logic             pend_o
);

  // Same layout as ch_state_t but sized by this instance's DIV_W.
  typedef struct packed {
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_q;
    logic             pend_v;
    logic             out;
    logic             tick;
  } st_t;

  st_t  st_q;
  st_t  st_d;
  logic wrap;
  logic realign;

  always_comb begin
    st_d      = st_q;
    st_d.tick = 1'b0;

    wrap    = (st_q.cnt == st_q.div_q);
    // Disabled and sync share one path: counter and output park at zero
    // and any waiting divisor becomes active straight away.
    realign = !en_i || sync_i;

    if (realign || wrap) begin
      st_d.cnt = '0;
      // Boundary point: a write landing here takes effect directly and
      // supersedes anything still waiting, so pend_v never rises.
      if (wr_i) begin
        st_d.div_q  = wr_data_i;
        st_d.pend_v = 1'b0;
      end else if (st_q.pend_v) begin
        st_d.div_q  = st_q.pend_q;
        st_d.pend_v = 1'b0;
      end
      if (realign) begin
        st_d.out = 1'b0;
      end else begin
        st_d.out  = ~st_q.out;
        st_d.tick = 1'b1;
      end
    end else begin
      st_d.cnt = st_q.cnt + DIV_W'(1);
      // Mid half-period: park the value until the wrap so the current
      // half-period is never shortened or stretched (last write wins).
      if (wr_i) begin
        st_d.pend_q = wr_data_i;
        st_d.pend_v = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q.cnt    <= '0;
      st_q.div_q  <= DIV_W'(DEFAULT_DIV);
      st_q.pend_q <= '0;
      st_q.pend_v <= 1'b0;
      st_q.out    <= 1'b0;
      st_q.tick   <= 1'b0;
    end else begin
      st_q <= st_d;
    end
  end

  assign out_o  = st_q.out;
  assign tick_o = st_q.tick;
  assign pend_o = st_q.pend_v;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers with glitch-free divisor updates.
// Latency: all outputs registered; no combinational input-to-output path.
// Backpressure: none; a divisor write is taken every cycle div_wr is high.
//
// Optional build macro MULTI_CLOCK_DIVIDER_SYNC_EN adds the 'sync' input,
// which realigns every enabled channel to phase zero in one cycle.
//
// Ports:
//   input_clock   system clock, posedge
//   reset         synchronous active-high reset
//   ch_en         per-channel run enable
//   div_wr        divisor write strobe
//   div_sel       channel targeted by div_wr (out-of-range values ignored)
//   div_data      divisor value
//   sync          (macro builds only) phase realign pulse
//   output_clock  per-channel divided square output
//   tick          per-channel one-cycle wrap strobe
//   div_pending   per-channel written divisor awaiting its wrap
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int SEL_W      = sel_width(NUM_CH)
) (
  input  logic              input_clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_data,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] output_clock,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pending
);

  logic              sync_all;
  logic [NUM_CH-1:0] wr_ch;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Select decode; a select value beyond NUM_CH-1 matches no channel.
    assign wr_ch[i] = div_wr && (int'(div_sel) == i);

    clock_divider_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (input_clock),
      .rst_i     (reset),
      .en_i      (ch_en[i]),
      .sync_i    (sync_all),
      .wr_i      (wr_ch[i]),
      .wr_data_i (div_data),
      .out_o     (output_clock[i]),
      .tick_o    (tick[i]),
      .pend_o    (div_pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 31;

  logic              input_clock = 1'b0;
  logic              reset       = 1'b1;
  logic [NUM_CH-1:0] ch_en       = '0;
  logic              div_wr      = 1'b0;
  logic [1:0]        div_sel     = '0;
  logic [DIV_W-1:0]  div_data    = '0;
  logic              sync        = 1'b0;
  logic [NUM_CH-1:0] output_clock;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pending;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_clock_divider dut (
    .input_clock  (input_clock),
    .reset        (reset),
    .ch_en        (ch_en),
    .div_wr       (div_wr),
    .div_sel      (div_sel),
    .div_data     (div_data),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    .sync         (sync),
`endif
    .output_clock (output_clock),
    .tick         (tick),
    .div_pending  (div_pending)
  );

  always #5 input_clock = ~input_clock;

  // Reference model: each channel counts down the cycles left in the
  // current half-period and flips its output when that reaches zero.
  int m_div  [NUM_CH];
  int m_pend [NUM_CH];
  int m_left [NUM_CH];
  bit m_pv   [NUM_CH];
  bit m_out  [NUM_CH];
  bit m_tick [NUM_CH];

  always @(posedge input_clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      bit wr;
      wr = div_wr && (int'(div_sel) == i);
      if (reset) begin
        m_div[i] = 1; m_pv[i] = 0; m_pend[i] = 0;
        m_out[i] = 0; m_tick[i] = 0; m_left[i] = 2;
      end else if (!ch_en[i] || sync) begin
        m_out[i] = 0; m_tick[i] = 0;
        if (wr) begin m_div[i] = int'(div_data); m_pv[i] = 0; end
        else if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
        m_left[i] = m_div[i] + 1;
      end else begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_out[i] = !m_out[i]; m_tick[i] = 1;
          if (wr) begin m_div[i] = int'(div_data); m_pv[i] = 0; end
          else if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
          m_left[i] = m_div[i] + 1;
        end else begin
          m_tick[i] = 0;
          if (wr) begin m_pend[i] = int'(div_data); m_pv[i] = 1; end
        end
      end
    end
  end

  function automatic logic [NUM_CH-1:0] m_vec(input int which);
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = (which == 0) ? m_out[i] : (which == 1) ? m_tick[i] : m_pv[i];
    return v;
  endfunction

  task automatic step();
    @(posedge input_clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; ch_en = '0; div_wr = 1; div_sel = 0; div_data = 7;
    step(); step();
    div_wr = 0;
    tests_run++;
    if (output_clock !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_out: got %b expected 0000", output_clock);
    end
    tests_run++;
    if (tick !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_tick: got %b expected 0000", tick);
    end
    tests_run++;
    if (div_pending !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_pend: got %b expected 0000", div_pending);
    end
  endtask

  task automatic test_default_div();
    reset = 0; ch_en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests_run++;
      if (tick[0] !== ((k % 2) == 0)) begin
        tests_failed++; $display("FAIL div1_tick k=%0d: got %b expected %b", k, tick[0], (k % 2) == 0);
      end
      tests_run++;
      if (output_clock[0] !== (((k / 2) % 2) == 1)) begin
        tests_failed++; $display("FAIL div1_out k=%0d: got %b expected %b", k, output_clock[0], ((k / 2) % 2) == 1);
      end
      tests_run++;
      if ({output_clock[3:1], tick[3:1], div_pending} !== 10'b0) begin
        tests_failed++; $display("FAIL div1_idle k=%0d: got %b expected 0", k, {output_clock[3:1], tick[3:1], div_pending});
      end
    end
    ch_en = '0; step();
  endtask

  task automatic test_pending_write();
    ch_en = 4'b0010; div_wr = 1; div_sel = 1; div_data = 3;
    step();
    div_wr = 0;
    tests_run++;
    if (div_pending[1] !== 1'b1 || tick[1] !== 1'b0) begin
      tests_failed++; $display("FAIL pend_set: got pend=%b tick=%b expected pend=1 tick=0", div_pending[1], tick[1]);
    end
    step();
    tests_run++;
    if ({div_pending[1], tick[1], output_clock[1]} !== 3'b011) begin
      tests_failed++; $display("FAIL pend_apply: got %b expected 011", {div_pending[1], tick[1], output_clock[1]});
    end
    for (int k = 3; k <= 18; k++) begin
      step();
      tests_run++;
      if ({div_pending[1], tick[1], output_clock[1]} !==
          {1'b0, ((k - 2) % 4) == 0, 1'b1 ^ (((k - 2) / 4) % 2 == 1)}) begin
        tests_failed++;
        $display("FAIL pend_half4 k=%0d: got %b expected %b", k, {div_pending[1], tick[1], output_clock[1]},
                 {1'b0, ((k - 2) % 4) == 0, 1'b1 ^ (((k - 2) / 4) % 2 == 1)});
      end
    end
    ch_en = '0; step();
  endtask

  task automatic test_write_at_wrap();
    ch_en = 4'b0100;
    step();
    div_wr = 1; div_sel = 2; div_data = 2;
    step();
    div_wr = 0;
    tests_run++;
    if ({div_pending[2], tick[2], output_clock[2]} !== 3'b011) begin
      tests_failed++; $display("FAIL wrapwr_first: got %b expected 011", {div_pending[2], tick[2], output_clock[2]});
    end
    for (int k = 3; k <= 11; k++) begin
      step();
      tests_run++;
      if ({div_pending[2], tick[2], output_clock[2]} !==
          {1'b0, ((k - 2) % 3) == 0, 1'b1 ^ (((k - 2) / 3) % 2 == 1)}) begin
        tests_failed++;
        $display("FAIL wrapwr_half3 k=%0d: got %b expected %b", k, {div_pending[2], tick[2], output_clock[2]},
                 {1'b0, ((k - 2) % 3) == 0, 1'b1 ^ (((k - 2) / 3) % 2 == 1)});
      end
    end
    ch_en = '0; step();
  endtask

  task automatic test_div_zero();
    div_wr = 1; div_sel = 3; div_data = 0;
    step();
    div_wr = 0;
    tests_run++;
    if (div_pending[3] !== 1'b0) begin
      tests_failed++; $display("FAIL div0_nopend: got %b expected 0", div_pending[3]);
    end
    ch_en = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests_run++;
      if ({tick[3], output_clock[3]} !== {1'b1, (k % 2) == 1}) begin
        tests_failed++; $display("FAIL div0_run k=%0d: got %b expected %b", k, {tick[3], output_clock[3]}, {1'b1, (k % 2) == 1});
      end
    end
    ch_en = '0;
    step();
    tests_run++;
    if ({tick[3], output_clock[3]} !== 2'b00) begin
      tests_failed++; $display("FAIL div0_disable: got %b expected 00", {tick[3], output_clock[3]});
    end
  endtask

  task automatic test_reset_midrun();
    ch_en = 4'b1111;
    step();
    for (int s = 0; s < NUM_CH; s++) begin
      div_wr = 1; div_sel = 2'(s); div_data = DIV_W'(5 + s);
      step();
      tests_run++;
      if ({output_clock, tick, div_pending} !== {m_vec(0), m_vec(1), m_vec(2)}) begin
        tests_failed++; $display("FAIL midrun_model s=%0d: got %b expected %b", s,
                                 {output_clock, tick, div_pending}, {m_vec(0), m_vec(1), m_vec(2)});
      end
    end
    reset = 1; div_wr = 1; div_sel = 1; div_data = 9;
    step();
    tests_run++;
    if ({output_clock, tick, div_pending} !== 12'b0) begin
      tests_failed++; $display("FAIL midrun_reset: got %b expected 0", {output_clock, tick, div_pending});
    end
    reset = 0; div_wr = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      tests_run++;
      if ({tick, output_clock} !== {((k % 2) == 0) ? 4'hF : 4'h0, (((k / 2) % 2) == 1) ? 4'hF : 4'h0}) begin
        tests_failed++; $display("FAIL midrun_div1 k=%0d: got %b expected %b", k, {tick, output_clock},
                                 {((k % 2) == 0) ? 4'hF : 4'h0, (((k / 2) % 2) == 1) ? 4'hF : 4'h0});
      end
    end
    ch_en = '0; step();
  endtask

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  task automatic test_sync();
    reset = 1; step();
    reset = 0; div_wr = 1; div_sel = 1; div_data = 2;
    step();
    div_wr = 0; ch_en = 4'b0011;
    repeat (5) step();
    sync = 1;
    step();
    sync = 0;
    tests_run++;
    if ({output_clock[1:0], tick[1:0]} !== 4'b0000) begin
      tests_failed++; $display("FAIL sync_clear: got %b expected 0000", {output_clock[1:0], tick[1:0]});
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (tick[1:0] !== {k == 3, k == 2}) begin
        tests_failed++; $display("FAIL sync_realign k=%0d: got %b expected %b", k, tick[1:0], {k == 3, k == 2});
      end
    end
    ch_en = '0; step();
  endtask
`endif

  task automatic test_random();
    reset = 1; step();
    reset = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_CH; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
      div_wr   = ($urandom_range(0, 2) == 0);
      div_sel  = 2'($urandom_range(0, 3));
      div_data = DIV_W'($urandom_range(0, 4));
      reset    = ($urandom_range(0, 99) == 0);
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      sync     = ($urandom_range(0, 49) == 0);
`endif
      step();
      tests_run++;
      if (output_clock !== m_vec(0)) begin
        tests_failed++; $display("FAIL rand_out c=%0d: got %b expected %b", c, output_clock, m_vec(0));
      end
      tests_run++;
      if (tick !== m_vec(1)) begin
        tests_failed++; $display("FAIL rand_tick c=%0d: got %b expected %b", c, tick, m_vec(1));
      end
      tests_run++;
      if (div_pending !== m_vec(2)) begin
        tests_failed++; $display("FAIL rand_pend c=%0d: got %b expected %b", c, div_pending, m_vec(2));
      end
    end
    reset = 0; sync = 0; div_wr = 0; ch_en = '0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_pending_write();
    test_write_at_wrap();
    test_div_zero();
    test_reset_midrun();
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    test_sync();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised successor to the single fixed-ratio divider; NUM_CH independent channels, each with a runtime-programmable divisor.
- Each channel produces a toggled square output and a one-cycle tick strobe.
- Sits between the system clock and game-timing consumers (tank movement, bullet step, animation, VGA-side blink).
- Divisor changes are glitch-free: applied only at a channel's wrap point.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- DIV_W, 31, divisor/counter width in bits.
- DEFAULT_DIV, 1, divisor loaded into every channel on reset.

Ports:
- input_clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable.
- div_wr  input  1  divisor write strobe, one cycle.
- div_sel  input  $clog2(NUM_CH) (min 1)  target channel of div_wr.
- div_data  input  DIV_W  new divisor value.
- output_clock  output  NUM_CH  per-channel divided square output.
- tick  output  NUM_CH  one-cycle strobe at each channel wrap.
- div_pending  output  NUM_CH  high while a written divisor awaits its wrap.

Behaviour:
- Reset, same cycle for all channels:
  - cnt=0, div_q=DEFAULT_DIV, pend_q=0, pend_v=0.
  - output_clock=0, tick=0, div_pending=0.
- Per channel i, when ch_en[i]=1:
  - cnt==div_q: cnt<=0, output_clock[i] toggles, tick[i]<=1 for one cycle.
  - Otherwise: cnt<=cnt+1, tick[i]<=0.
  - Half-period = div_q+1 cycles; full period = 2*(div_q+1). With div=1, toggles every 2 cycles, period 4.
  - div_q=0: toggles every cycle, tick held high continuously.
- Outputs are registered, with no combinational path from inputs.
- First tick/toggle occurs div_q+1 cycles after ch_en rises from the reset/idle state.
- ch_en[i]=0:
  - cnt<=0, output_clock[i]<=0, tick[i]<=0.
  - A pending divisor is applied the next cycle: div_q<=pend_q, pend_v<=0.
- Divisor write (div_wr=1, channel div_sel):
  - Enabled channel, not wrapping this cycle: pend_q<=div_data, pend_v<=1. A later write before the wrap overwrites pend_q (last write wins).
  - Enabled channel wrapping this same cycle: div_q<=div_data directly, pend_v<=0. The write wins over any older pending value.
  - Disabled channel: div_q<=div_data immediately.
  - div_sel >= NUM_CH: write ignored.
- At a wrap with pend_v=1: div_q<=pend_q, pend_v<=0. The new divisor governs the next half-period.
- div_pending[i] = pend_v[i], registered.
- Counter compare is exact equality on DIV_W bits. Counter never exceeds div_q because the divisor only changes at wrap or while disabled.
- Reset mid-operation: everything returns to reset values the next cycle. Writes in the reset cycle are discarded.

Optional Feature:
- Macro: MULTI_CLOCK_DIVIDER_SYNC_EN.
- Defined: adds input port sync (1 bit). sync=1 forces cnt<=0, output_clock<=0 and tick<=0 on all enabled channels in one cycle, realigning phases; pending divisors are applied at that moment. sync has lower priority than reset and higher priority than wrap.
- Not defined: no sync port; channels free-run independently.

Decomposition:
- Package clk_div_pkg holds:
  - default constants: NUM_CH_DEF, DIV_W_DEF, DEFAULT_DIV_DEF.
  - typedef div_t = logic [DIV_W_DEF-1:0].
  - typedef ch_state_t struct {cnt, div_q, pend_q, pend_v, out, tick}.
- Sub-module clock_divider_ch: one channel (counter, divisor/pending registers, output flops). The top instantiates NUM_CH copies in a generate loop and decodes div_wr/div_sel to a per-channel write strobe.

Test Plan:
- Reset, then ch_en=4'b0001, DEFAULT_DIV=1 -> output_clock[0] period 4 cycles (2 high/2 low), tick[0] every 2 cycles, first tick 2 cycles after enable; other channels stay 0.
- Write div_data=3 to ch1 mid-half-period -> div_pending[1]=1 until the next wrap; the following half-periods are 4 cycles; no short or runt pulse.
- Write ch2 on the exact cycle ch2 wraps -> new divisor used immediately; div_pending[2] never asserts.
- div_q=0 on ch3 -> output_clock[3] toggles every cycle and tick[3] stays high; drop ch_en[3] -> output and tick go to 0 the next cycle.
- Assert reset mid-run with pending writes on all channels -> all outputs 0 and div_pending=0 the next cycle; divisors back to 1.
- With MULTI_CLOCK_DIVIDER_SYNC_EN: run ch0 div=1 and ch1 div=2, pulse sync -> both outputs 0 the next cycle; ch0 ticks 2 cycles later and ch1 ticks 3 cycles later.
